// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_pkg
//  Description : Shared types and constants for the I2C target block.
//  Revision    : 1.0 - initial release
// ============================================================================
package i2c_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_DATA_W = 8;

    // Protocol phase of the target engine
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ADDR      = 3'd1,
        ADDR_ACK  = 3'd2,
        WRITE     = 3'd3,
        WRITE_ACK = 3'd4,
        READ      = 3'd5,
        READ_ACK  = 3'd6,
        WAIT_STOP = 3'd7
    } i2c_target_state_t;

endpackage
`default_nettype wire

// File: rtl/i2c_in_filter.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_in_filter
//  Description : Two-flop synchronizer followed by a glitch filter. The
//                filtered output only changes once FILTER_LEN consecutive
//                synchronized samples disagree with it.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_in_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_filt
);

    localparam int                 c_CNT_W    = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(FILTER_LEN - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    logic [1:0]         r_sync;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_filt;

    // Synchronize the bus level, then accept a new level only after it persists
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= 2'b11;
            r_cnt  <= '0;
            r_filt <= 1'b1;
        end else begin
            r_sync <= {r_sync[0], i_raw};
            if (r_sync[1] == r_filt) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_LAST) begin
                r_filt <= r_sync[1];
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end
        end
    end

    assign o_filt = r_filt;

endmodule
`default_nettype wire

// File: rtl/i2c_target.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_target
//  Description : I2C target (slave) with 7-bit address match, byte write
//                and byte read paths. Bus lines are synchronized and
//                glitch-filtered before edge/condition detection.
//                Optional build macro I2C_TARGET_STRETCH_EN enables SCL clock
//                stretching while read data is not yet available; without
//                it SCL is never driven and 8'hFF is sent when no data.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_target
    import i2c_pkg::*;
#(
    parameter int FILTER_LEN = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scl_i,
    input  logic                  sda_i,
    output logic                  sda_o,
    output logic                  sda_t,
    output logic                  scl_o,
    output logic                  scl_t,
    input  logic [I2C_ADDR_W-1:0] own_addr,
    output logic [I2C_DATA_W-1:0] rx_data,
    output logic                  rx_valid,
    input  logic [I2C_DATA_W-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  start_det,
    output logic                  stop_det,
    output logic                  rd_wr,
    output logic                  busy
);

    // ------------------------------------------------------------------
    // Input conditioning and bus event detection
    // ------------------------------------------------------------------
    logic w_scl_f;
    logic w_sda_f;
    logic r_scl_prev;
    logic r_sda_prev;

    i2c_in_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
        .clk    (clk),
        .rst    (rst),
        .i_raw  (scl_i),
        .o_filt (w_scl_f)
    );

    i2c_in_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
        .clk    (clk),
        .rst    (rst),
        .i_raw  (sda_i),
        .o_filt (w_sda_f)
    );

    logic w_scl_rise;
    logic w_scl_fall;
    logic w_start;
    logic w_stop;

    assign w_scl_rise = w_scl_f & ~r_scl_prev;
    assign w_scl_fall = ~w_scl_f & r_scl_prev;
    assign w_start    = w_scl_f & r_scl_prev & r_sda_prev & ~w_sda_f;
    assign w_stop     = w_scl_f & r_scl_prev & ~r_sda_prev & w_sda_f;

    // ------------------------------------------------------------------
    // Engine state
    // ------------------------------------------------------------------
    i2c_target_state_t           r_state;
    logic [3:0]                  r_bit_cnt;
    logic [6:0]                  r_shift;      // received bits so far, newest in LSB
    logic [6:0]                  r_tx_shift;   // remaining read bits after the one on the bus
    logic                        r_phase;      // ACK slots: second half reached
    logic [I2C_ADDR_W-1:0]       r_own_addr;
    logic                        r_sda_o;
    logic                        r_sda_t;
    logic [I2C_DATA_W-1:0]       r_rx_data;
    logic                        r_rx_valid;
    logic                        r_tx_ready;
    logic                        r_start_det;
    logic                        r_stop_det;
    logic                        r_rd_wr;
    logic                        r_busy;
    logic [I2C_DATA_W-1:0]       w_rx_byte;
    logic                        w_load;
    logic                        w_stalled;

    // Byte as it stands once the bit now on SDA is included
    assign w_rx_byte = {r_shift, w_sda_f};

`ifdef I2C_TARGET_STRETCH_EN
    logic r_stretch;
    logic r_scl_t;
    assign w_stalled = r_stretch;
    assign scl_t     = r_scl_t;
`else
    assign w_stalled = 1'b0;
    assign scl_t     = 1'b1;
`endif

    // A read byte starts on the falling edge closing an ACK slot, or when stalled data arrives
    always_comb begin
        w_load = 1'b0;
        if (!w_start && !w_stop) begin
            if (w_scl_fall && r_phase &&
                ((r_state == ADDR_ACK && r_rd_wr) || r_state == READ_ACK)) begin
                w_load = 1'b1;
            end
`ifdef I2C_TARGET_STRETCH_EN
            if (r_state == READ && r_stretch && tx_valid) begin
                w_load = 1'b1;
            end
`endif
        end
    end

    // Protocol engine: START/STOP override everything, then byte loads, then per-state SCL edges
    always_ff @(posedge clk) begin
        if (rst) begin
            r_scl_prev  <= 1'b1;
            r_sda_prev  <= 1'b1;
            r_state     <= IDLE;
            r_bit_cnt   <= 4'd0;
            r_shift     <= 7'd0;
            r_tx_shift  <= 7'd0;
            r_phase     <= 1'b0;
            r_own_addr  <= '0;
            r_sda_o     <= 1'b1;
            r_sda_t     <= 1'b1;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_tx_ready  <= 1'b0;
            r_start_det <= 1'b0;
            r_stop_det  <= 1'b0;
            r_rd_wr     <= 1'b0;
            r_busy      <= 1'b0;
`ifdef I2C_TARGET_STRETCH_EN
            r_stretch   <= 1'b0;
            r_scl_t     <= 1'b1;
`endif
        end else begin
            r_scl_prev  <= w_scl_f;
            r_sda_prev  <= w_sda_f;
            r_sda_o     <= 1'b0;
            r_rx_valid  <= 1'b0;
            r_tx_ready  <= 1'b0;
            r_start_det <= w_start;
            r_stop_det  <= w_stop;

            if (w_start) begin
                r_state    <= ADDR;
                r_bit_cnt  <= 4'd0;
                r_phase    <= 1'b0;
                r_sda_t    <= 1'b1;
                r_own_addr <= own_addr;
`ifdef I2C_TARGET_STRETCH_EN
                r_stretch  <= 1'b0;
                r_scl_t    <= 1'b1;
`endif
            end else if (w_stop) begin
                r_state   <= IDLE;
                r_bit_cnt <= 4'd0;
                r_phase   <= 1'b0;
                r_sda_t   <= 1'b1;
                r_busy    <= 1'b0;
`ifdef I2C_TARGET_STRETCH_EN
                r_stretch <= 1'b0;
                r_scl_t   <= 1'b1;
`endif
            end else if (w_load) begin
                r_state   <= READ;
                r_bit_cnt <= 4'd0;
                r_phase   <= 1'b0;
                if (tx_valid) begin
                    r_tx_shift <= tx_data[6:0];
                    r_sda_t    <= tx_data[7];
                    r_tx_ready <= 1'b1;
`ifdef I2C_TARGET_STRETCH_EN
                    r_stretch  <= 1'b0;
                    r_scl_t    <= 1'b1;
`endif
                end else begin
`ifdef I2C_TARGET_STRETCH_EN
                    // Hold SCL low until the application supplies a byte
                    r_stretch <= 1'b1;
                    r_scl_t   <= 1'b0;
                    r_sda_t   <= 1'b1;
`else
                    // Nothing to send: leave SDA released for all eight bits
                    r_tx_shift <= 7'h7F;
                    r_sda_t    <= 1'b1;
`endif
                end
            end else begin
                case (r_state)
                    ADDR: begin
                        if (w_scl_rise) begin
                            r_shift <= w_rx_byte[6:0];
                            if (r_bit_cnt == 4'd7) begin
                                r_bit_cnt <= 4'd0;
                                if (w_rx_byte[7:1] == r_own_addr) begin
                                    r_rd_wr <= w_rx_byte[0];
                                    r_busy  <= 1'b1;
                                    r_phase <= 1'b0;
                                    r_state <= ADDR_ACK;
                                end else begin
                                    r_busy  <= 1'b0;
                                    r_sda_t <= 1'b1;
                                    r_state <= WAIT_STOP;
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 4'd1;
                            end
                        end
                    end

                    // ACK is driven between the 8th and 9th falling edges; a read
                    // address leaves via the byte load above instead
                    ADDR_ACK, WRITE_ACK: begin
                        if (w_scl_fall) begin
                            if (!r_phase) begin
                                r_sda_t <= 1'b0;
                                r_phase <= 1'b1;
                            end else begin
                                r_sda_t   <= 1'b1;
                                r_phase   <= 1'b0;
                                r_bit_cnt <= 4'd0;
                                r_state   <= WRITE;
                            end
                        end
                    end

                    WRITE: begin
                        if (w_scl_rise) begin
                            r_shift <= w_rx_byte[6:0];
                            if (r_bit_cnt == 4'd7) begin
                                r_rx_data  <= w_rx_byte;
                                r_rx_valid <= 1'b1;
                                r_bit_cnt  <= 4'd0;
                                r_phase    <= 1'b0;
                                r_state    <= WRITE_ACK;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 4'd1;
                            end
                        end
                    end

                    READ: begin
                        if (!w_stalled) begin
                            if (w_scl_rise) begin
                                r_bit_cnt <= r_bit_cnt + 4'd1;
                            end else if (w_scl_fall) begin
                                if (r_bit_cnt == 4'd8) begin
                                    r_sda_t   <= 1'b1;
                                    r_bit_cnt <= 4'd0;
                                    r_phase   <= 1'b0;
                                    r_state   <= READ_ACK;
                                end else begin
                                    r_sda_t    <= r_tx_shift[6];
                                    r_tx_shift <= {r_tx_shift[5:0], 1'b0};
                                end
                            end
                        end
                    end

                    // Master ACK continues the read on the next falling edge; NACK ends it
                    READ_ACK: begin
                        if (w_scl_rise) begin
                            if (w_sda_f) begin
                                r_state <= WAIT_STOP;
                            end else begin
                                r_phase <= 1'b1;
                            end
                        end
                    end

                    IDLE, WAIT_STOP: begin
                        r_sda_t <= 1'b1;
                    end

                    default: begin
                        r_state <= IDLE;
                        r_sda_t <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign sda_o     = r_sda_o;
    assign sda_t     = r_sda_t;
    assign scl_o     = 1'b0;
    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign tx_ready  = r_tx_ready;
    assign start_det = r_start_det;
    assign stop_det  = r_stop_det;
    assign rd_wr     = r_rd_wr;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_i2c_target.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_target
//  Description : Self-checking bench for i2c_target: bus-level master model
//                with wired-AND lines, scenario tasks and a randomized
//                transaction loop checked against expected transfer lists.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_i2c_target;

    localparam int FILTER_LEN = 4;
    localparam int Q          = 16;     // clk cycles per SCL quarter phase

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_o, sda_t, scl_o, scl_t;
    logic       scl_line, sda_line;
    logic [6:0] own_addr = 7'h50;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       start_det, stop_det, rd_wr, busy;

    int n_vec = 0;
    int n_err = 0;

    // Monitor-owned counters (cumulative; tests compare deltas)
    int n_start = 0;
    int n_stop  = 0;
    int n_txr   = 0;
    int n_drv   = 0;
    int tx_idx  = 0;
    logic [7:0] rx_got[$];

    // Bench-owned read data supply
    logic [7:0] tx_bytes [64];
    int         tx_cnt = 0;

    always #5 clk = ~clk;

    assign scl_line = scl_m & (scl_t | scl_o);
    assign sda_line = sda_m & (sda_t | sda_o);
    assign tx_valid = (tx_cnt != tx_idx);
    assign tx_data  = tx_bytes[tx_idx[5:0]];

    i2c_target #(.FILTER_LEN(FILTER_LEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .scl_i     (scl_line),
        .sda_i     (sda_line),
        .sda_o     (sda_o),
        .sda_t     (sda_t),
        .scl_o     (scl_o),
        .scl_t     (scl_t),
        .own_addr  (own_addr),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .start_det (start_det),
        .stop_det  (stop_det),
        .rd_wr     (rd_wr),
        .busy      (busy)
    );

    // Observe DUT pulses away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            if (start_det) n_start++;
            if (stop_det)  n_stop++;
            if (rx_valid)  rx_got.push_back(rx_data);
            if (sda_t === 1'b0) n_drv++;
            if (tx_ready) begin
                n_txr++;
                tx_idx++;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Master bus model
    // ------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic scl_high();
        int t;
        t = 0;
        scl_m = 1'b1;
        @(negedge clk);
        while (scl_line !== 1'b1 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 5000) begin
            n_vec++; n_err++;
            $display("FAIL scl_release: scl=%b required 1", scl_line);
        end
    endtask

    task automatic offer_tx(input logic [7:0] b);
        tx_bytes[tx_cnt % 64] = b;
        tx_cnt++;
    endtask

    task automatic m_start();
        sda_m = 1'b1; tick(Q);
        scl_high();   tick(Q);
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic m_stop();
        sda_m = 1'b0; tick(Q);
        scl_high();   tick(Q);
        sda_m = 1'b1; tick(Q);
    endtask

    task automatic m_wbit(input logic b);
        sda_m = b; tick(Q);
        scl_high(); tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic m_rbit(output logic b);
        sda_m = 1'b1; tick(Q);
        scl_high(); tick(Q / 2);
        b = sda_line; tick(Q / 2);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic m_wbyte(input logic [7:0] d, output logic nak);
        for (int i = 7; i >= 0; i--) m_wbit(d[i]);
        m_rbit(nak);
    endtask

    task automatic m_rbyte(output logic [7:0] d, input logic nak);
        logic b;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            m_rbit(b);
            d = {d[6:0], b};
        end
        m_wbit(nak);
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        tick(5);
        n_vec++;
        if ({sda_o, sda_t, scl_o, scl_t, rx_valid, tx_ready, start_det, stop_det, rd_wr, busy} !== 10'b1101000000) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b required %b",
                     {sda_o, sda_t, scl_o, scl_t, rx_valid, tx_ready, start_det, stop_det, rd_wr, busy}, 10'b1101000000);
        end
        n_vec++;
        if (rx_data !== 8'h00) begin
            n_err++; $display("FAIL reset_rx_data: got %h required 00", rx_data);
        end
        rst = 1'b0;
        tick(20);
    endtask

    task automatic test_write();
        logic nak;
        int   rx0, st0;
        rx0 = rx_got.size(); st0 = n_stop;
        own_addr = 7'h50;
        m_start();
        m_wbyte(8'hA0, nak);
        n_vec++; if (nak !== 1'b0) begin n_err++; $display("FAIL write_addr_ack: got %b required 0", nak); end
        n_vec++; if ({busy, rd_wr} !== 2'b10) begin n_err++; $display("FAIL write_busy_rdwr: got %b required 10", {busy, rd_wr}); end
        m_wbyte(8'h3C, nak);
        n_vec++; if (nak !== 1'b0) begin n_err++; $display("FAIL write_b0_ack: got %b required 0", nak); end
        m_wbyte(8'h81, nak);
        n_vec++; if (nak !== 1'b0) begin n_err++; $display("FAIL write_b1_ack: got %b required 0", nak); end
        m_stop(); tick(10);
        n_vec++;
        if (rx_got.size() - rx0 !== 2) begin
            n_err++; $display("FAIL write_rx_count: got %0d required 2", rx_got.size() - rx0);
        end else if (rx_got[rx0] !== 8'h3C || rx_got[rx0 + 1] !== 8'h81) begin
            n_err++; $display("FAIL write_rx_data: got %h %h required 3c 81", rx_got[rx0], rx_got[rx0 + 1]);
        end
        n_vec++; if (busy !== 1'b0 || n_stop - st0 !== 1) begin
            n_err++; $display("FAIL write_stop: busy %b stops %0d required 0 1", busy, n_stop - st0);
        end
    endtask

    task automatic test_nack();
        logic nak;
        int   rx0, d0;
        rx0 = rx_got.size(); d0 = n_drv;
        own_addr = 7'h50;
        m_start();
        m_wbyte(8'hA2, nak);
        n_vec++; if (nak !== 1'b1) begin n_err++; $display("FAIL nack_addr: got %b required 1", nak); end
        m_wbyte(8'h55, nak);
        n_vec++; if (nak !== 1'b1) begin n_err++; $display("FAIL nack_data: got %b required 1", nak); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL nack_busy: got %b required 0", busy); end
        m_stop(); tick(10);
        n_vec++; if (rx_got.size() != rx0 || n_drv != d0) begin
            n_err++; $display("FAIL nack_silent: rx %0d drive clks %0d required 0 0", rx_got.size() - rx0, n_drv - d0);
        end
    endtask

    task automatic test_read();
        logic       nak;
        logic [7:0] d;
        int         t0, d0;
        t0 = n_txr;
        own_addr = 7'h50;
        offer_tx(8'h5A); offer_tx(8'hC3);
        m_start();
        m_wbyte(8'hA1, nak);
        n_vec++; if (nak !== 1'b0) begin n_err++; $display("FAIL read_addr_ack: got %b required 0", nak); end
        n_vec++; if ({busy, rd_wr} !== 2'b11) begin n_err++; $display("FAIL read_busy_rdwr: got %b required 11", {busy, rd_wr}); end
        m_rbyte(d, 1'b0);
        n_vec++; if (d !== 8'h5A) begin n_err++; $display("FAIL read_b0: got %h required 5a", d); end
        m_rbyte(d, 1'b1);
        n_vec++; if (d !== 8'hC3) begin n_err++; $display("FAIL read_b1: got %h required c3", d); end
        n_vec++; if (n_txr - t0 !== 2) begin n_err++; $display("FAIL read_tx_ready: got %0d required 2", n_txr - t0); end
        // After the NACK the target must stay off the bus until STOP
        d0 = n_drv;
        m_rbyte(d, 1'b1);
        n_vec++; if (d !== 8'hFF || n_drv != d0 || n_txr - t0 !== 2) begin
            n_err++; $display("FAIL read_wait_stop: data %h drive clks %0d tx_ready %0d required ff 0 2", d, n_drv - d0, n_txr - t0);
        end
        m_stop(); tick(10);
    endtask

    task automatic test_back_to_back();
        logic       nak;
        logic [7:0] d;
        int         s0, rx0;
        s0 = n_start; rx0 = rx_got.size();
        own_addr = 7'h50;
        offer_tx(8'h77);
        m_start();
        m_wbyte(8'hA0, nak);
        m_wbyte(8'h10, nak);
        n_vec++; if (rx_got.size() - rx0 !== 1 || rx_got[rx_got.size() - 1] !== 8'h10) begin
            n_err++; $display("FAIL rstart_write: count %0d required 1 with data 10", rx_got.size() - rx0);
        end
        m_start();
        m_wbyte(8'hA1, nak);
        n_vec++; if (nak !== 1'b0 || rd_wr !== 1'b1) begin
            n_err++; $display("FAIL rstart_addr: ack %b rd_wr %b required 0 1", nak, rd_wr);
        end
        n_vec++; if (n_start - s0 !== 2) begin n_err++; $display("FAIL rstart_count: got %0d required 2", n_start - s0); end
        m_rbyte(d, 1'b1);
        n_vec++; if (d !== 8'h77) begin n_err++; $display("FAIL rstart_read: got %h required 77", d); end
        m_stop(); tick(10);
    endtask

    task automatic test_glitch();
        int s0;
        s0 = n_start;
        sda_m = 1'b0; tick(2);
        sda_m = 1'b1; tick(30);
        n_vec++; if (n_start != s0) begin n_err++; $display("FAIL glitch_start: got %0d required 0", n_start - s0); end
    endtask

    task automatic test_reset_mid_read();
        logic nak;
        own_addr = 7'h50;
        offer_tx(8'h5A);
        m_start();
        m_wbyte(8'hA1, nak);
        n_vec++; if (sda_t !== 1'b0) begin n_err++; $display("FAIL midread_drive: got %b required 0", sda_t); end
        rst = 1'b1;
        @(posedge clk); #1;
        n_vec++; if (sda_t !== 1'b1 || busy !== 1'b0) begin
            n_err++; $display("FAIL midread_release: sda_t %b busy %b required 1 0", sda_t, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        tick(10);
        m_stop(); tick(20);
    endtask

`ifdef I2C_TARGET_STRETCH_EN
    task automatic test_stretch();
        logic       nak;
        logic [7:0] d;
        int         bad;
        own_addr = 7'h50;
        tx_cnt = tx_idx;
        m_start();
        m_wbyte(8'hA1, nak);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            if (scl_t !== 1'b0) bad++;
            @(negedge clk);
        end
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL stretch_hold: released %0d clks required 0", bad); end
        offer_tx(8'h96);
        @(negedge clk);
        n_vec++; if (scl_t !== 1'b1) begin n_err++; $display("FAIL stretch_release: got %b required 1", scl_t); end
        m_rbyte(d, 1'b1);
        n_vec++; if (d !== 8'h96) begin n_err++; $display("FAIL stretch_data: got %h required 96", d); end
        m_stop(); tick(10);
    endtask
`else
    task automatic test_no_tx();
        logic       nak;
        logic [7:0] d;
        int         t0;
        own_addr = 7'h50;
        tx_cnt = tx_idx;
        t0 = n_txr;
        m_start();
        m_wbyte(8'hA1, nak);
        m_rbyte(d, 1'b1);
        n_vec++; if (d !== 8'hFF || n_txr != t0 || scl_t !== 1'b1) begin
            n_err++; $display("FAIL no_tx: data %h tx_ready %0d scl_t %b required ff 0 1", d, n_txr - t0, scl_t);
        end
        m_stop(); tick(10);
    endtask
`endif

    // Randomized transactions checked against the expected transfer lists
    task automatic test_random();
        logic       nak;
        logic [7:0] d;
        logic [7:0] exp_bytes[$];
        logic [6:0] own, addr;
        int         mode, n, rx0, t0, d0;
        for (int k = 0; k < 8; k++) begin
            own  = 7'($urandom_range(0, 127));
            mode = $urandom_range(0, 2);
            n    = $urandom_range(1, 3);
            addr = (mode == 1) ? (own ^ 7'($urandom_range(1, 127))) : own;
            exp_bytes.delete();
            for (int i = 0; i < n; i++) exp_bytes.push_back(8'($urandom_range(0, 255)));
            own_addr = own;
            rx0 = rx_got.size(); t0 = n_txr; d0 = n_drv;
            if (mode == 2) foreach (exp_bytes[i]) offer_tx(exp_bytes[i]);
            m_start();
            m_wbyte({addr, (mode == 2) ? 1'b1 : 1'b0}, nak);
            n_vec++; if (nak !== (mode == 1)) begin
                n_err++; $display("FAIL rand_addr_ack[%0d]: got %b required %b", k, nak, (mode == 1));
            end
            for (int i = 0; i < n; i++) begin
                if (mode == 2) begin
                    m_rbyte(d, (i == n - 1));
                    n_vec++; if (d !== exp_bytes[i]) begin
                        n_err++; $display("FAIL rand_read[%0d.%0d]: got %h required %h", k, i, d, exp_bytes[i]);
                    end
                end else begin
                    m_wbyte(exp_bytes[i], nak);
                    n_vec++; if (nak !== (mode == 1)) begin
                        n_err++; $display("FAIL rand_data_ack[%0d.%0d]: got %b required %b", k, i, nak, (mode == 1));
                    end
                end
            end
            m_stop(); tick(10);
            n_vec++;
            case (mode)
                0: begin
                    if (rx_got.size() - rx0 != n) begin
                        n_err++; $display("FAIL rand_rx_count[%0d]: got %0d required %0d", k, rx_got.size() - rx0, n);
                    end else begin
                        for (int i = 0; i < n; i++) if (rx_got[rx0 + i] !== exp_bytes[i]) begin
                            n_err++; $display("FAIL rand_rx_data[%0d.%0d]: got %h required %h", k, i, rx_got[rx0 + i], exp_bytes[i]);
                        end
                    end
                end
                1: if (rx_got.size() != rx0 || n_drv != d0) begin
                    n_err++; $display("FAIL rand_silent[%0d]: rx %0d drive clks %0d required 0 0", k, rx_got.size() - rx0, n_drv - d0);
                end
                default: if (n_txr - t0 != n) begin
                    n_err++; $display("FAIL rand_tx_ready[%0d]: got %0d required %0d", k, n_txr - t0, n);
                end
            endcase
            n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rand_busy_after_stop[%0d]: got %b required 0", k, busy); end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_nack();
        test_read();
        test_back_to_back();
        test_glitch();
        test_reset_mid_read();
`ifdef I2C_TARGET_STRETCH_EN
        test_stretch();
`else
        test_no_tx();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
